// File: rtl/trdb_branch_map.sv
// trdb_branch_map
// Collects the outcome of each retired conditional branch into a bit map
// plus an entry count. A flush from the packet-type selector freezes the
// current map/count into snapshot registers for the payload builder and
// restarts accumulation (seeded with a concurrent branch, if any).
// Map encoding: 1 = not taken, 0 = taken.

module trdb_branch_map #(
    parameter int BRANCH_MAP_LEN   = 31,
    parameter int BRANCH_COUNT_LEN = 5
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        valid_i,
    input  logic                        is_branch_i,
    input  logic                        branch_taken_i,
    input  logic                        flush_i,
    output logic [BRANCH_MAP_LEN-1:0]   map_o,
    output logic [BRANCH_COUNT_LEN-1:0] count_o,
    output logic                        full_o,
    output logic                        snap_valid_o,
    output logic [BRANCH_MAP_LEN-1:0]   snap_map_o,
    output logic [BRANCH_COUNT_LEN-1:0] snap_count_o,
    output logic [BRANCH_COUNT_LEN-1:0] snap_branches_o,
    output logic                        overflow_o
);

    localparam logic [BRANCH_COUNT_LEN-1:0] FULL_COUNT = BRANCH_COUNT_LEN'(BRANCH_MAP_LEN);
    localparam logic [BRANCH_COUNT_LEN-1:0] ONE_COUNT  = BRANCH_COUNT_LEN'(1);
    localparam logic [BRANCH_MAP_LEN-1:0]   ONE_MAP    = BRANCH_MAP_LEN'(1);

    logic [BRANCH_MAP_LEN-1:0]   map_q,           map_d;
    logic [BRANCH_COUNT_LEN-1:0] count_q,         count_d;
    logic                        snap_valid_q,    snap_valid_d;
    logic [BRANCH_MAP_LEN-1:0]   snap_map_q,      snap_map_d;
    logic [BRANCH_COUNT_LEN-1:0] snap_count_q,    snap_count_d;
    logic [BRANCH_COUNT_LEN-1:0] snap_branches_q, snap_branches_d;
    logic                        overflow_q,      overflow_d;

    logic                        accept_s;
    logic                        full_s;
    logic [BRANCH_MAP_LEN-1:0]   new_bit_s;

    assign accept_s  = valid_i && is_branch_i;
    assign full_s    = (count_q == FULL_COUNT);
    // Outcome bit for the incoming branch, placed at bit 0 (shifted later).
    assign new_bit_s = branch_taken_i ? {BRANCH_MAP_LEN{1'b0}} : ONE_MAP;

    // Next-state computation for the live map, snapshot and overflow flag.
    always_comb begin
        map_d           = map_q;
        count_d         = count_q;
        snap_valid_d    = 1'b0;
        snap_map_d      = snap_map_q;
        snap_count_d    = snap_count_q;
        snap_branches_d = snap_branches_q;
        overflow_d      = overflow_q;

        if (flush_i) begin
            // Snapshot always reflects the pre-edge state; a concurrent
            // branch belongs to the next packet.
            snap_valid_d    = 1'b1;
            snap_map_d      = map_q;
            snap_count_d    = count_q;
            // A full map is encoded as 0 in the payload branches field.
            snap_branches_d = full_s ? {BRANCH_COUNT_LEN{1'b0}} : count_q;
            if (accept_s) begin
                map_d   = new_bit_s;
                count_d = ONE_COUNT;
            end else begin
                map_d   = {BRANCH_MAP_LEN{1'b0}};
                count_d = {BRANCH_COUNT_LEN{1'b0}};
            end
        end else if (accept_s) begin
            if (full_s) begin
                // No room left: drop the branch and remember it.
                overflow_d = 1'b1;
            end else begin
                map_d   = map_q | (new_bit_s << count_q);
                count_d = count_q + ONE_COUNT;
            end
        end else begin
            map_d   = map_q;
            count_d = count_q;
        end
    end

    // State registers with synchronous reset taking priority over all inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            map_q           <= {BRANCH_MAP_LEN{1'b0}};
            count_q         <= {BRANCH_COUNT_LEN{1'b0}};
            snap_valid_q    <= 1'b0;
            snap_map_q      <= {BRANCH_MAP_LEN{1'b0}};
            snap_count_q    <= {BRANCH_COUNT_LEN{1'b0}};
            snap_branches_q <= {BRANCH_COUNT_LEN{1'b0}};
            overflow_q      <= 1'b0;
        end else begin
            map_q           <= map_d;
            count_q         <= count_d;
            snap_valid_q    <= snap_valid_d;
            snap_map_q      <= snap_map_d;
            snap_count_q    <= snap_count_d;
            snap_branches_q <= snap_branches_d;
            overflow_q      <= overflow_d;
        end
    end

    assign map_o           = map_q;
    assign count_o         = count_q;
    assign full_o          = full_s;
    assign snap_valid_o    = snap_valid_q;
    assign snap_map_o      = snap_map_q;
    assign snap_count_o    = snap_count_q;
    assign snap_branches_o = snap_branches_q;
    assign overflow_o      = overflow_q;

endmodule

// File: tb/tb_trdb_branch_map.sv
// Self-checking bench for trdb_branch_map: a reference model predicts
// every output after each clock edge and pushes it to a scoreboard queue,
// which is popped and compared once the DUT has updated.

module tb_trdb_branch_map;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        is_branch_i = 1'b0;
    logic        branch_taken_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [30:0] map_o;
    logic [4:0]  count_o;
    logic        full_o;
    logic        snap_valid_o;
    logic [30:0] snap_map_o;
    logic [4:0]  snap_count_o;
    logic [4:0]  snap_branches_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [30:0] map;
        logic [4:0]  count;
        logic        full;
        logic        sv;
        logic [30:0] smap;
        logic [4:0]  scount;
        logic [4:0]  sbr;
        logic        ovf;
    } exp_t;

    exp_t sb_q[$];

    // Reference model state
    logic [30:0] m_map = 31'd0;
    int          m_count = 0;
    logic        m_sv = 1'b0;
    logic [30:0] m_smap = 31'd0;
    int          m_scount = 0;
    int          m_sbr = 0;
    logic        m_ovf = 1'b0;

    trdb_branch_map #(
        .BRANCH_MAP_LEN  (31),
        .BRANCH_COUNT_LEN(5)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .is_branch_i    (is_branch_i),
        .branch_taken_i (branch_taken_i),
        .flush_i        (flush_i),
        .map_o          (map_o),
        .count_o        (count_o),
        .full_o         (full_o),
        .snap_valid_o   (snap_valid_o),
        .snap_map_o     (snap_map_o),
        .snap_count_o   (snap_count_o),
        .snap_branches_o(snap_branches_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one edge for the given inputs and push the prediction.
    task automatic model_step(input logic v, input logic b, input logic t, input logic f, input logic r);
        exp_t e;
        logic acc;
        acc  = v && b;
        m_sv = 1'b0;
        if (r) begin
            m_map = 31'd0; m_count = 0; m_smap = 31'd0; m_scount = 0; m_sbr = 0; m_ovf = 1'b0;
        end else if (f) begin
            m_sv     = 1'b1;
            m_smap   = m_map;
            m_scount = m_count;
            m_sbr    = (m_count == 31) ? 0 : m_count;
            m_map    = 31'd0;
            m_count  = 0;
            if (acc) begin
                m_map[0] = ~t;
                m_count  = 1;
            end
        end else if (acc) begin
            if (m_count == 31) begin
                m_ovf = 1'b1;
            end else begin
                m_map[m_count] = ~t;
                m_count = m_count + 1;
            end
        end
        e.map    = m_map;
        e.count  = 5'(m_count);
        e.full   = (m_count == 31);
        e.sv     = m_sv;
        e.smap   = m_smap;
        e.scount = 5'(m_scount);
        e.sbr    = 5'(m_sbr);
        e.ovf    = m_ovf;
        sb_q.push_back(e);
    endtask

    // One clock cycle: drive at negedge, predict, compare #1 after posedge.
    task automatic step(input logic v, input logic b, input logic t, input logic f, input logic r);
        exp_t e;
        valid_i = v; is_branch_i = b; branch_taken_i = t; flush_i = f; rst_i = r;
        model_step(v, b, t, f, r);
        @(posedge clk_i);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check_eq("map",           {1'b0, map_o},        {1'b0, e.map});
            check_eq("count",         {27'd0, count_o},     {27'd0, e.count});
            check_eq("full",          {31'd0, full_o},      {31'd0, e.full});
            check_eq("snap_valid",    {31'd0, snap_valid_o},{31'd0, e.sv});
            check_eq("snap_map",      {1'b0, snap_map_o},   {1'b0, e.smap});
            check_eq("snap_count",    {27'd0, snap_count_o},{27'd0, e.scount});
            check_eq("snap_branches", {27'd0, snap_branches_o}, {27'd0, e.sbr});
            check_eq("overflow",      {31'd0, overflow_o},  {31'd0, e.ovf});
        end
        @(negedge clk_i);
    endtask

    initial begin
        @(negedge clk_i);
        // Reset, then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("idle_map", {1'b0, map_o}, 32'd0);

        // T, N, N, T -> 0b0110
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("tp_map4", {1'b0, map_o}, 32'h6);
        check_eq("tp_count4", {27'd0, count_o}, 32'd4);

        // Flush alone
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("tp_snap_map", {1'b0, snap_map_o}, 32'h6);
        check_eq("tp_snap_count", {27'd0, snap_count_o}, 32'd4);
        check_eq("tp_snap_br", {27'd0, snap_branches_o}, 32'd4);
        check_eq("tp_snap_pulse", {31'd0, snap_valid_o}, 32'd1);
        check_eq("tp_map_clr", {1'b0, map_o}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("tp_pulse_end", {31'd0, snap_valid_o}, 32'd0);

        // Flush with empty map
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check_eq("empty_pulse", {31'd0, snap_valid_o}, 32'd1);

        // 31 not-taken branches, with a valid non-branch mixed in
        for (int i = 0; i < 31; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
            if (i == 10) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        check_eq("tp_full_map", {1'b0, map_o}, 32'h7FFFFFFF);
        check_eq("tp_full", {31'd0, full_o}, 32'd1);

        // 32nd branch dropped
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("tp_ovf", {31'd0, overflow_o}, 32'd1);
        check_eq("tp_ovf_count", {27'd0, count_o}, 32'd31);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Full + flush + taken branch
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        check_eq("tp_ff_scount", {27'd0, snap_count_o}, 32'd31);
        check_eq("tp_ff_sbr", {27'd0, snap_branches_o}, 32'd0);
        check_eq("tp_ff_count", {27'd0, count_o}, 32'd1);
        check_eq("tp_ovf_sticky", {31'd0, overflow_o}, 32'd1);

        // Back-to-back flushes
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // 3 branches, then reset with flush and branch
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, i[0], 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        check_eq("tp_rst_pulse", {31'd0, snap_valid_o}, 32'd0);
        check_eq("tp_rst_ovf", {31'd0, overflow_o}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_eq("tp_nonbr_count", {27'd0, count_o}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
